pipe_adder_nbit: RTL
====================

# pipe_adder_nbit

Pipelined, parametrised N-bit adder/subtractor with a valid/ready handshake on both sides. It is the next generation of the team's combinational n-bit full adder. Operands are split into `STAGES` equal slices, and the carry ripples one slice per clock, so wide adds close timing at high frequency. It sits between any producer and consumer that speak valid/ready, and it sustains one result per cycle under full throughput with back-pressure.

## Interface
Parameters:
- `BIT`, 16: operand and result width; must be a multiple of `STAGES`.
- `STAGES`, 4: pipeline depth, equal to the number of slices; 1 ≤ `STAGES` ≤ `BIT`. Slice width `SL` = `BIT`/`STAGES`.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `valid_i`  in  1  input beat valid.
- `ready_o`  out  1  block can accept a beat this cycle.
- `a_i`  in  `BIT`  operand A.
- `b_i`  in  `BIT`  operand B.
- `cin_i`  in  1  carry-in; used only when `sub_i`=0.
- `sub_i`  in  1  0: A+B+cin; 1: A−B, computed as A+~B+1 with `cin_i` ignored.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  downstream accepts result.
- `sum_o`  out  `BIT`  result.
- `cout_o`  out  1  carry out of MSB; in subtract mode, 1 means no borrow.
- `ovf_o`  out  1  two's-complement signed overflow (see Configuration).

## Operation
- A beat is accepted when `valid_i` && `ready_o`. A result is consumed when `valid_o` && `ready_i`.
- Stage k (0..`STAGES`−1) holds:
  - a valid bit `v[k]`;
  - completed sum slices 0..k;
  - the carry out of slice k;
  - the unprocessed upper slices of A and the effective B (B, or ~B in subtract mode);
  - sign bits for overflow.
- Stage 0 adds slice 0 with the effective carry-in. Stage k>0 adds slice k of its input register with the carry from stage k−1.
- Flow control:
  - enable `en[k]` = !`v[k]` || `en[k+1]`, with `en[STAGES]` = `ready_i`.
  - A stage loads only when `en[k]` is high. Its valid bit loads `v[k−1]`, or `valid_i` for k=0.
  - `ready_o` = `en[0]`.
  - Bubbles collapse: an empty stage accepts data even while downstream is stalled.
- Outputs are driven directly from the last stage register: `valid_o` = `v[STAGES−1]`, plus its sum, carry and overflow bits.
- Result order equals acceptance order. No beat is dropped or duplicated.
- Output data is held stable while `valid_o` && !`ready_i`.

## Timing
- Reset (asynchronous assert, synchronous release): all `v[k]`=0 and all data registers=0. This gives `valid_o`=0, `sum_o`=0, `cout_o`=0, `ovf_o`=0.
- Latency: a beat accepted at edge n appears on `valid_o` after edge n+`STAGES`−1, i.e. visible in cycle n+`STAGES`, provided no stall occurs.
- Throughput: 1 beat/cycle while `ready_i`=1.
- Capacity: `STAGES` beats in flight. With `ready_i` held low, `ready_o` falls only once all stages are valid.
- Simultaneous accept and consume when full is allowed: `ready_o`=1 whenever `ready_i`=1.
- `ready_o` depends combinationally on `ready_i`; this is the only combinational in-to-out path.
- Reset mid-operation: all in-flight beats are discarded and `valid_o` falls immediately, asynchronously.
- `STAGES`=1: a single registered adder with latency 1.

## Configuration
- `PIPE_ADDER_OVF_EN` defined:
  - `ovf_o` = (signA == signB_eff) && (signSum != signA), registered alongside the result.
  - signB_eff is the sign of the effective B.
- Not defined:
  - overflow logic and sign pipeline registers are omitted;
  - `ovf_o` is tied to 0;
  - the port list is unchanged.

## Structure
- Package `pipe_adder_pkg`:
  - default `BIT`/`STAGES` constants;
  - `mode_e` typedef (`MODE_ADD`, `MODE_SUB`).
  - Width-dependent types stay in the module.
- Sub-module `pipe_add_stage`:
  - one registered slice stage, parametrised by `SL` and the remaining width;
  - it has `en`, valid-in/valid-out and carry-in/carry-out.
  - The top module instantiates `STAGES` copies in a generate loop and computes the `en` chain.

## Test plan
Defaults are `BIT`=16, `STAGES`=4.
- **Carry across all slices:** `a_i`=0xFFFF, `b_i`=0x0001, `cin_i`=0, `sub_i`=0, accepted at cycle 0 → `valid_o` in cycle 4 with `sum_o`=0x0000, `cout_o`=1, `ovf_o`=0.
- **Subtract with borrow:** `sub_i`=1, `a_i`=0x0005, `b_i`=0x0007, `cin_i`=1 (must be ignored) → `sum_o`=0xFFFE, `cout_o`=0, `ovf_o`=0.
- **Signed overflow:** 0x7FFF+0x0001 → `sum_o`=0x8000, `cout_o`=0, `ovf_o`=1 with `PIPE_ADDER_OVF_EN`; `ovf_o`=0 without it.
- **Streaming:** 8 back-to-back random beats, with `ready_i`=1 throughout → 8 results on consecutive cycles, in order, each matching a reference model of (a + b_eff + c) mod 2^16.
- **Back-pressure:**
  - `ready_i`=0 for 6 cycles while beats are offered every cycle → exactly 4 beats accepted, then `ready_o`=0;
  - `sum_o` stays stable throughout;
  - raising `ready_i` drains all 4 in order while new beats are accepted in the same cycles.
- **Reset mid-flight:** assert `rst_ni`=0 with 3 beats in flight → `valid_o`=0 and `sum_o`=0 immediately; after release, no stale results emerge.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared constants and types for the pipelined adder/subtractor.
package pipe_adder_pkg;

    localparam int unsigned BIT_DEF    = 16;
    localparam int unsigned STAGES_DEF = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/pipe_add_stage.sv
// One registered slice of the carry-ripple pipeline.
// The stage word packs, from LSB up: completed sum slices, the remaining
// slices of A, and the remaining slices of effective B. Each stage replaces
// its A slice with the slice sum and drops its B slice, so the word shrinks
// by SL bits per stage and the last stage holds exactly the BIT-wide sum.
// Optional overflow flag under PIPE_ADDER_OVF_EN.
module pipe_add_stage
    import pipe_adder_pkg::*;
#(
    parameter int unsigned  BIT   = 16,
    parameter int unsigned  SL    = 4,
    parameter int unsigned  K     = 0,
    localparam int unsigned W_IN  = 2 * BIT - K * SL,
    localparam int unsigned W_OUT = W_IN - SL
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             valid_i,
    output logic             valid_o,
    input  logic             cin_i,
    output logic             cout_o,
    input  logic [W_IN-1:0]  w_i,
    output logic [W_OUT-1:0] w_o
`ifdef PIPE_ADDER_OVF_EN
    ,
    input  logic             ovf_i,
    output logic             ovf_o
`endif
);

    localparam int unsigned DONE_W = K * SL;
    localparam int unsigned SW     = SL + 1;
    localparam bit          LAST   = (DONE_W + SL == BIT);

    logic [SL:0]      slice_d;
    logic [W_IN-1:0]  merged;
    logic [W_OUT-1:0] w_d;
    logic             v_q;
    logic             c_q;
    logic [W_OUT-1:0] w_q;

    // Add this slice, splice the result into the A field, drop the B slice.
    always_comb begin
        slice_d = {1'b0, w_i[DONE_W +: SL]} + {1'b0, w_i[BIT +: SL]} + SW'(cin_i);
        merged  = w_i;
        merged[DONE_W +: SL] = slice_d[SL-1:0];
        w_d     = W_OUT'({merged >> (BIT + SL), merged[BIT-1:0]});
    end

    // Stage register: loads whenever the enable chain lets it advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            w_q <= '0;
        end else if (en_i) begin
            v_q <= valid_i;
            c_q <= slice_d[SL];
            w_q <= w_d;
        end
    end

    assign valid_o = v_q;
    assign cout_o  = c_q;
    assign w_o     = w_q;

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Overflow is resolved where the sign slice is added; earlier stages pass through.
    always_comb begin
        ovf_d = ovf_i;
        if (LAST) begin
            ovf_d = (w_i[BIT-1] == w_i[W_IN-1]) && (slice_d[SL-1] != w_i[BIT-1]);
        end
    end

    // Overflow register moves with the rest of the stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (en_i) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: rtl/pipe_adder_nbit.sv
// Pipelined N-bit adder/subtractor with valid/ready on both sides.
// Carry ripples one slice per clock; bubbles collapse under back-pressure.
// Define PIPE_ADDER_OVF_EN to enable the signed-overflow output.
module pipe_adder_nbit
    import pipe_adder_pkg::*;
#(
    parameter int unsigned BIT    = BIT_DEF,
    parameter int unsigned STAGES = STAGES_DEF
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [BIT-1:0] a_i,
    input  logic [BIT-1:0] b_i,
    input  logic           cin_i,
    input  logic           sub_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [BIT-1:0] sum_o,
    output logic           cout_o,
    output logic           ovf_o
);

    localparam int unsigned SL = BIT / STAGES;

    mode_e             mode;
    logic [BIT-1:0]    b_eff;
    logic              cin_eff;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] en;

    // Operand conditioning: subtract is A + ~B + 1, carry-in ignored.
    always_comb begin
        mode    = mode_e'(sub_i);
        b_eff   = (mode == MODE_SUB) ? ~b_i : b_i;
        cin_eff = (mode == MODE_SUB) ? 1'b1 : cin_i;
    end

    // Enable chain: a stage advances if it is empty or everything below it can move.
    always_comb begin
        logic full;
        full = 1'b1;
        en   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full  = full & v[k];
            en[k] = ready_i | ~full;
        end
    end

    assign ready_o = en[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned W_IN  = 2 * BIT - k * SL;
        localparam int unsigned W_OUT = W_IN - SL;

        logic [W_IN-1:0]  w_in;
        logic [W_OUT-1:0] w_out;
        logic             c_in;
        logic             c_out;
        logic             v_in;
        logic             v_out;
`ifdef PIPE_ADDER_OVF_EN
        logic             ovf_in;
        logic             ovf_out;
`endif

        if (k == 0) begin : g_first
            assign w_in = {b_eff, a_i};
            assign c_in = cin_eff;
            assign v_in = valid_i;
`ifdef PIPE_ADDER_OVF_EN
            assign ovf_in = 1'b0;
`endif
        end else begin : g_next
            assign w_in = g_stage[k-1].w_out;
            assign c_in = g_stage[k-1].c_out;
            assign v_in = g_stage[k-1].v_out;
`ifdef PIPE_ADDER_OVF_EN
            assign ovf_in = g_stage[k-1].ovf_out;
`endif
        end

        pipe_add_stage #(
            .BIT (BIT),
            .SL  (SL),
            .K   (k)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .en_i    (en[k]),
            .valid_i (v_in),
            .valid_o (v_out),
            .cin_i   (c_in),
            .cout_o  (c_out),
            .w_i     (w_in),
            .w_o     (w_out)
`ifdef PIPE_ADDER_OVF_EN
            ,
            .ovf_i   (ovf_in),
            .ovf_o   (ovf_out)
`endif
        );

        assign v[k] = v_out;
    end

    assign valid_o = v[STAGES-1];
    assign sum_o   = g_stage[STAGES-1].w_out;
    assign cout_o  = g_stage[STAGES-1].c_out;
`ifdef PIPE_ADDER_OVF_EN
    assign ovf_o   = g_stage[STAGES-1].ovf_out;
`else
    assign ovf_o   = 1'b0;
`endif

endmodule
